// File: rtl/oven_key_encoder.sv
// ---------------------------------------------------------------------------
// oven_key_encoder
//   Front-end input conditioner for the oven controller. Turns the raw
//   active-low KEY0/KEY1 push-buttons and the step-select slide switches into
//   clean one-cycle increment / decrement / confirm commands. Each inc/dec
//   command carries the step value picked by the switches for the current
//   entry mode.
//
//   Ports
//     clk           in   system clock
//     rst           in   synchronous reset, active-high
//     key0          in   increment button, active-low, asynchronous
//     key1          in   decrement button, active-low, asynchronous
//     sw[5:0]       in   step-select switches, asynchronous
//     mode          in   0 = temperature steps, 1 = time steps
//     inc_pulse     out  one-cycle increment command
//     dec_pulse     out  one-cycle decrement command
//     confirm_pulse out  one-cycle confirm (both keys) command
//     step[8:0]     out  step value in the inc/dec pulse cycle, else 0
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// oven_key_debounce
//   One key lane: 2-flop synchroniser followed by a stable-run debouncer.
//
//   Ports
//     clk        in   system clock
//     rst        in   synchronous reset, active-high
//     i_key_n    in   raw key, active-low, asynchronous
//     o_pressed  out  debounced pressed level (1 = pressed)
// ---------------------------------------------------------------------------
module oven_key_debounce #(
  parameter int STABLE = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_pressed
);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pressed;

  assign w_pressed = ~r_s2;
  assign o_pressed = r_db;

  // The synchroniser resets to "released" so a key held across reset has to
  // walk through the full stable run again before it registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b1;
      r_s2  <= 1'b1;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_key_n;
      r_s2 <= r_s1;
      if (w_pressed != r_db) begin
        // r_cnt counts how many consecutive cycles the new level has been
        // seen; the last of STABLE such cycles flips the debounced level.
        if (r_cnt >= CNT_W'(STABLE - 1)) begin
          r_db  <= w_pressed;
          r_cnt <= '0;
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // Back to the current level: any glitch restarts the run.
        r_cnt <= '0;
      end
    end
  end

endmodule

module oven_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_WINDOW    = 2500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key0,
  input  logic       key1,
  input  logic [5:0] sw,
  input  logic       mode,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       confirm_pulse,
  output logic [8:0] step
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > CHORD_WINDOW) ? DEBOUNCE_CYCLES : CHORD_WINDOW;
  localparam int MAX_CD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    HOLD,
    WAIT_RELEASE
  } state_t;

  // ---- input conditioning -------------------------------------------------
  logic [1:0] w_keys_n;
  logic [1:0] w_db;
  logic [5:0] r_sw_s1;
  logic [5:0] r_sw_s2;

  assign w_keys_n = {key1, key0};

  for (genvar g = 0; g < 2; g++) begin : g_key
    oven_key_debounce #(
      .STABLE (DEBOUNCE_CYCLES),
      .CNT_W  (CNT_W)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .i_key_n   (w_keys_n[g]),
      .o_pressed (w_db[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // ---- step decode ----------------------------------------------------------
  // Full 6-bit match: sw[5] must be low and exactly one of sw[4:0] set,
  // everything else decodes to 0 (which later suppresses the pulse).
  logic [8:0] w_step;

  always_comb begin
    w_step = '0;
    case (r_sw_s2)
      6'b000001: w_step = 9'd5;
      6'b000010: w_step = 9'd10;
      6'b000100: w_step = mode ? 9'd30  : 9'd25;
      6'b001000: w_step = mode ? 9'd60  : 9'd50;
      6'b010000: w_step = mode ? 9'd300 : 9'd100;
      default:   w_step = '0;
    endcase
  end

  // ---- command FSM ----------------------------------------------------------
  state_t           r_state;
  logic             r_latch;        // 0 = key0 (inc), 1 = key1 (dec)
  logic [CNT_W-1:0] r_wcnt;         // cycles spent in PENDING
  logic [CNT_W-1:0] r_rcnt;         // cycles since last pulse in HOLD
  logic             r_rep_started;  // first auto-repeat already issued
  logic             r_inc;
  logic             r_dec;
  logic             r_conf;
  logic [8:0]       r_step;

  logic             w_held;
  logic             w_other;
  logic [CNT_W-1:0] w_rep_lim;

  assign w_held    = r_latch ? w_db[1] : w_db[0];
  assign w_other   = r_latch ? w_db[0] : w_db[1];
  assign w_rep_lim = r_rep_started ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1);

  // Pulses default low every cycle so each command is exactly one cycle wide.
  // An inc/dec with an invalid step keeps the outputs low but the FSM still
  // moves on exactly as if the pulse had gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_latch       <= 1'b0;
      r_wcnt        <= '0;
      r_rcnt        <= '0;
      r_rep_started <= 1'b0;
      r_inc         <= 1'b0;
      r_dec         <= 1'b0;
      r_conf        <= 1'b0;
      r_step        <= '0;
    end else begin
      r_inc  <= 1'b0;
      r_dec  <= 1'b0;
      r_conf <= 1'b0;
      r_step <= '0;

      case (r_state)
        IDLE: begin
          if (w_db[0] && w_db[1]) begin
            r_conf  <= 1'b1;
            r_state <= WAIT_RELEASE;
          end else if (w_db[0] || w_db[1]) begin
            r_latch <= w_db[1];
            r_wcnt  <= '0;
            r_state <= PENDING;
          end
        end

        PENDING: begin
          // Chord check comes first so it also wins a tie with the window
          // expiry.
          if (w_other) begin
            r_conf  <= 1'b1;
            r_state <= WAIT_RELEASE;
          end else if (!w_held) begin
            if (w_step != '0) begin
              r_inc  <= ~r_latch;
              r_dec  <= r_latch;
              r_step <= w_step;
            end
            r_state <= IDLE;
          end else if (r_wcnt >= CNT_W'(CHORD_WINDOW - 1)) begin
            if (w_step != '0) begin
              r_inc  <= ~r_latch;
              r_dec  <= r_latch;
              r_step <= w_step;
            end
            r_rcnt        <= '0;
            r_rep_started <= 1'b0;
            r_state       <= HOLD;
          end else if (r_wcnt != '1) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end

        HOLD: begin
          if (w_other) begin
            r_state <= WAIT_RELEASE;
          end else if (!w_held) begin
            r_state <= IDLE;
          end else if (r_rcnt >= w_rep_lim) begin
            if (w_step != '0) begin
              r_inc  <= ~r_latch;
              r_dec  <= r_latch;
              r_step <= w_step;
            end
            r_rcnt        <= '0;
            r_rep_started <= 1'b1;
          end else if (r_rcnt != '1) begin
            r_rcnt <= r_rcnt + 1'b1;
          end
        end

        WAIT_RELEASE: begin
          if (!w_db[0] && !w_db[1]) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign inc_pulse     = r_inc;
  assign dec_pulse     = r_dec;
  assign confirm_pulse = r_conf;
  assign step          = r_step;

endmodule

// File: tb/tb_oven_key_encoder.sv
// Bench for oven_key_encoder with short timing parameters. A cycle-level
// reference model built on raw-sample histories and absolute event times
// runs alongside every clock; directed sequences and a switch/tap table
// check the headline behaviours against hand-derived constants.
module tb_oven_key_encoder;

  localparam int D  = 4;
  localparam int W  = 10;
  localparam int RD = 20;
  localparam int RR = 5;

  localparam int PH_IDLE = 0;
  localparam int PH_PEND = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_WAIT = 3;

  localparam int STEP_T[5] = '{5, 10, 25, 50, 100};
  localparam int STEP_M[5] = '{5, 10, 30, 60, 300};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key0 = 1'b1;
  logic       key1 = 1'b1;
  logic [5:0] sw = '0;
  logic       mode = 1'b0;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       confirm_pulse;
  logic [8:0] step;

  oven_key_encoder #(
    .DEBOUNCE_CYCLES (D),
    .CHORD_WINDOW    (W),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key0          (key0),
    .key1          (key1),
    .sw            (sw),
    .mode          (mode),
    .inc_pulse     (inc_pulse),
    .dec_pulse     (dec_pulse),
    .confirm_pulse (confirm_pulse),
    .step          (step)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // pulse monitor
  int mon_inc, mon_dec, mon_conf, mon_step, mon_conf_cyc;
  int mon_pulses[$];

  // reference model state
  bit         hk0[$];
  bit         hk1[$];
  logic [5:0] hsw[$];
  int         last_rst = -1;
  int         m_ph = PH_IDLE;
  int         m_key = 0;
  int         m_expire = 0;
  int         m_next = 0;
  bit         m_db0 = 0;
  bit         m_db1 = 0;
  logic       e_inc, e_dec, e_conf;
  logic [8:0] e_step;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int decode_ref(logic [5:0] s, logic m);
    if (s[5] !== 1'b0 || $countones(s[4:0]) != 1) return 0;
    for (int i = 0; i < 5; i++)
      if (s[i]) return m ? STEP_M[i] : STEP_T[i];
    return 0;
  endfunction

  // raw key sample taken at edge idx; anything at or before a reset counts as released
  function automatic bit raw_k(int which, int idx);
    if (idx < 0 || idx <= last_rst) return 1'b1;
    return which ? hk1[idx] : hk0[idx];
  endfunction

  // all D synchronised samples feeding edge e equal v
  function automatic bit win_all(int which, int e, bit v);
    for (int i = e - 1 - D; i <= e - 2; i++)
      if (raw_k(which, i) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fire(int sv);
    if (sv != 0) begin
      e_inc  = (m_key == 0);
      e_dec  = (m_key == 1);
      e_step = 9'(sv);
    end
  endtask

  task automatic model_edge(int e, logic r_i, logic k0_i, logic k1_i, logic [5:0] sw_i, logic m_i);
    bit held, other;
    int sv;
    logic [5:0] s2;
    hk0.push_back(k0_i);
    hk1.push_back(k1_i);
    hsw.push_back(sw_i);
    e_inc = 0; e_dec = 0; e_conf = 0; e_step = '0;
    if (r_i) begin
      last_rst = e; m_ph = PH_IDLE; m_db0 = 0; m_db1 = 0;
      return;
    end
    s2 = (e - 2 < 0 || e - 2 <= last_rst) ? 6'd0 : hsw[e-2];
    sv = decode_ref(s2, m_i);
    held  = m_key ? m_db1 : m_db0;
    other = m_key ? m_db0 : m_db1;
    case (m_ph)
      PH_IDLE: begin
        if (m_db0 && m_db1) begin e_conf = 1; m_ph = PH_WAIT; end
        else if (m_db0 || m_db1) begin m_key = m_db1 ? 1 : 0; m_expire = e + W; m_ph = PH_PEND; end
      end
      PH_PEND: begin
        if (other) begin e_conf = 1; m_ph = PH_WAIT; end
        else if (!held) begin fire(sv); m_ph = PH_IDLE; end
        else if (e == m_expire) begin fire(sv); m_next = e + RD; m_ph = PH_HOLD; end
      end
      PH_HOLD: begin
        if (other) m_ph = PH_WAIT;
        else if (!held) m_ph = PH_IDLE;
        else if (e == m_next) begin fire(sv); m_next = e + RR; end
      end
      default: begin
        if (!m_db0 && !m_db1) m_ph = PH_IDLE;
      end
    endcase
    if (win_all(0, e, 1'b0)) m_db0 = 1; else if (win_all(0, e, 1'b1)) m_db0 = 0;
    if (win_all(1, e, 1'b0)) m_db1 = 1; else if (win_all(1, e, 1'b1)) m_db1 = 0;
  endtask

  task automatic tick();
    logic r_i, k0_i, k1_i, m_i;
    logic [5:0] sw_i;
    int e;
    r_i = rst; k0_i = key0; k1_i = key1; m_i = mode; sw_i = sw;
    e = cyc;
    @(posedge clk);
    model_edge(e, r_i, k0_i, k1_i, sw_i, m_i);
    #1;
    check("model", {inc_pulse, dec_pulse, confirm_pulse, step},
          {e_inc, e_dec, e_conf, e_step});
    if (inc_pulse === 1'b1 || dec_pulse === 1'b1) begin
      if (inc_pulse === 1'b1) mon_inc++; else mon_dec++;
      mon_step = step;
      mon_pulses.push_back(e);
    end
    if (confirm_pulse === 1'b1) begin mon_conf++; mon_conf_cyc = e; end
    cyc++;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_mon();
    mon_inc = 0; mon_dec = 0; mon_conf = 0; mon_step = 0; mon_conf_cyc = -1;
    mon_pulses.delete();
  endtask

  function automatic int pulse_at(int i);
    return (i < mon_pulses.size()) ? mon_pulses[i] : -1;
  endfunction

  // key0 pressed, key1 pressed 3 cycles later, both held, then released
  task automatic do_chord(string tag);
    int t0;
    clear_mon();
    t0 = cyc;
    key0 = 0; ticks(3);
    key1 = 0; ticks(27);
    key0 = 1; ticks(3);
    key1 = 1; ticks(20);
    check({tag, "_conf"}, mon_conf, 1);
    check({tag, "_conf_cyc"}, mon_conf_cyc, t0 + 9);
    check({tag, "_incdec"}, mon_inc + mon_dec, 0);
  endtask

  typedef struct {
    logic [5:0] sw;
    logic       mode;
    int         key;
    int         n_inc;
    int         n_dec;
    int         step;
  } vec_t;

  vec_t vt[12];

  initial begin
    int t0;
    logic [5:0] swl[8];

    vt[0]  = '{6'b000001, 1'b0, 0, 1, 0, 5};
    vt[1]  = '{6'b000010, 1'b0, 1, 0, 1, 10};
    vt[2]  = '{6'b000100, 1'b1, 0, 1, 0, 30};
    vt[3]  = '{6'b001000, 1'b0, 1, 0, 1, 50};
    vt[4]  = '{6'b001000, 1'b1, 0, 1, 0, 60};
    vt[5]  = '{6'b010000, 1'b1, 1, 0, 1, 300};
    vt[6]  = '{6'b010000, 1'b0, 0, 1, 0, 100};
    vt[7]  = '{6'b000011, 1'b0, 0, 0, 0, 0};
    vt[8]  = '{6'b100001, 1'b0, 0, 0, 0, 0};
    vt[9]  = '{6'b000000, 1'b1, 1, 0, 0, 0};
    vt[10] = '{6'b100000, 1'b0, 1, 0, 0, 0};
    vt[11] = '{6'b000100, 1'b0, 1, 0, 1, 25};
    swl = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
            6'b010000, 6'b000011, 6'b100001, 6'b000000};

    clear_mon();
    rst = 1; ticks(3);
    check("reset_outputs", {inc_pulse, dec_pulse, confirm_pulse, step}, 0);
    rst = 0; ticks(10);

    // bounce: toggles every 2 cycles for 12 cycles, then held low
    mode = 0; sw = 6'b000100; ticks(5);
    clear_mon(); t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      key0 = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
      tick();
    end
    key0 = 0; ticks(18);
    key0 = 1; ticks(25);
    check("bounce_inc", mon_inc, 1);
    check("bounce_cyc", pulse_at(0), t0 + 28);
    check("bounce_step", mon_step, 25);
    check("bounce_other", mon_dec + mon_conf, 0);

    // auto-repeat: key0 held 60 cycles
    mode = 0; sw = 6'b000001; ticks(5);
    clear_mon(); t0 = cyc;
    key0 = 0; ticks(60);
    key0 = 1; ticks(30);
    check("rep_count", mon_inc, 7);
    check("rep_first", pulse_at(0), t0 + 16);
    check("rep_delay", pulse_at(1), t0 + 36);
    check("rep_rate", pulse_at(2), t0 + 41);
    check("rep_last", pulse_at(6), t0 + 61);
    check("rep_step", mon_step, 5);

    // chord
    do_chord("chord");

    // table of switch patterns with a short tap on one key
    for (int i = 0; i < 12; i++) begin
      sw = vt[i].sw; mode = vt[i].mode; ticks(4);
      clear_mon();
      if (vt[i].key == 0) key0 = 0; else key1 = 0;
      ticks(8);
      key0 = 1; key1 = 1;
      ticks(20);
      check($sformatf("tap%0d_inc", i), mon_inc, vt[i].n_inc);
      check($sformatf("tap%0d_dec", i), mon_dec, vt[i].n_dec);
      check($sformatf("tap%0d_step", i), mon_step, vt[i].step);
    end

    // invalid switches still allow a chord confirm
    sw = 6'b100001; ticks(4);
    do_chord("badsw_chord");

    // reset in HOLD at the cycle the first repeat would fire
    mode = 0; sw = 6'b000001; ticks(5);
    clear_mon(); t0 = cyc;
    key0 = 0; ticks(36);
    check("prerst_inc", mon_inc, 1);
    rst = 1; tick();
    check("rst_outputs", {inc_pulse, dec_pulse, confirm_pulse, step}, 0);
    rst = 0;
    clear_mon();
    ticks(30);
    check("postrst_inc", mon_inc, 1);
    check("postrst_cyc", pulse_at(0), t0 + 53);
    key0 = 1; ticks(20);

    // randomized stimulus, model compared every cycle
    for (int s = 0; s < 120; s++) begin
      int prob, len;
      case ($urandom_range(0, 2))
        0: prob = 3;
        1: prob = 10;
        default: prob = 60;
      endcase
      len = $urandom_range(10, 40);
      if ($urandom_range(0, 3) == 0) sw = swl[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, prob - 1) == 0) key0 = ~key0;
        if ($urandom_range(0, prob - 1) == 0) key1 = ~key1;
        rst = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    rst = 0; key0 = 1; key1 = 1;
    ticks(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
